// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter
// Two-requester round-robin arbiter in front of a single APB master port.
// Each granted command is walked through SETUP and ACCESS; completion (normal,
// slave error or access timeout) is reported back to the owner as a one-cycle
// DONE pulse with RDATA/ERR that stay valid until that requester's next DONE.

module apb_master_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TO_CNT_W       = 8
) (
    input  logic              PCLK,
    input  logic              PRESET,
    // requester 0
    input  logic              R0_REQ,
    input  logic              R0_WRITE,
    input  logic [ADDR_W-1:0] R0_ADDR,
    input  logic [DATA_W-1:0] R0_WDATA,
    output logic              R0_DONE,
    output logic [DATA_W-1:0] R0_RDATA,
    output logic              R0_ERR,
    // requester 1
    input  logic              R1_REQ,
    input  logic              R1_WRITE,
    input  logic [ADDR_W-1:0] R1_ADDR,
    input  logic [DATA_W-1:0] R1_WDATA,
    output logic              R1_DONE,
    output logic [DATA_W-1:0] R1_RDATA,
    output logic              R1_ERR,
    // APB master port
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    localparam bit                TO_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [TO_CNT_W-1:0] TO_LIMIT = TO_CNT_W'(TIMEOUT_CYCLES);
    localparam logic [TO_CNT_W-1:0] CNT_MAX  = {TO_CNT_W{1'b1}};

    state_t              state_q, state_d;
    logic                last_q, last_d;     // requester granted most recently
    logic                gnt_q, gnt_d;       // owner of the transfer in flight
    logic [TO_CNT_W-1:0] cnt_q, cnt_d;       // PREADY=0 cycles seen in ACCESS
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic                done0_q, done0_d;
    logic                done1_q, done1_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;
    logic                err0_q, err0_d;
    logic                err1_q, err1_d;

    logic                elig0_s, elig1_s, pick_s;
    logic [TO_CNT_W-1:0] cnt_inc_s;
    logic                fin_s;
    logic                fin_err_s;
    logic [DATA_W-1:0]   fin_rdata_s;

    // Eligibility masks a requester in the cycle its DONE is visible so a
    // level REQ that has not yet dropped is not re-granted.
    always_comb begin
        elig0_s   = R0_REQ & ~done0_q;
        elig1_s   = R1_REQ & ~done1_q;
        pick_s    = (elig0_s & elig1_s) ? ~last_q : elig1_s;
        cnt_inc_s = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + {{(TO_CNT_W-1){1'b0}}, 1'b1});
    end

    // Next-state and next-output computation for the transfer sequencer.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        cnt_d       = cnt_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        err0_d      = err0_q;
        err1_d      = err1_q;
        fin_s       = 1'b0;
        fin_err_s   = 1'b0;
        fin_rdata_s = {DATA_W{1'b0}};

        case (state_q)
            ST_IDLE: begin
                if (elig0_s | elig1_s) begin
                    gnt_d     = pick_s;
                    last_d    = pick_s;
                    pwrite_d  = pick_s ? R1_WRITE : R0_WRITE;
                    paddr_d   = pick_s ? R1_ADDR  : R0_ADDR;
                    pwdata_d  = pick_s ? R1_WDATA : R0_WDATA;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = ST_SETUP;
                end else begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                cnt_d     = {TO_CNT_W{1'b0}};
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    fin_s       = 1'b1;
                    fin_err_s   = PSLVERR;
                    fin_rdata_s = pwrite_q ? {DATA_W{1'b0}} : PRDATA;
                end else if (TO_EN && (cnt_inc_s >= TO_LIMIT)) begin
                    fin_s       = 1'b1;
                    fin_err_s   = 1'b1;
                    fin_rdata_s = {DATA_W{1'b0}};
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase

        // Completion: close the APB access and report to the owner only.
        if (fin_s) begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            state_d   = ST_IDLE;
            if (gnt_q) begin
                done1_d  = 1'b1;
                rdata1_d = fin_rdata_s;
                err1_d   = fin_err_s;
            end else begin
                done0_d  = 1'b1;
                rdata0_d = fin_rdata_s;
                err0_d   = fin_err_s;
            end
        end else begin
            done0_d = 1'b0;
            done1_d = 1'b0;
        end
    end

    // State and output registers; reset leaves R1 as last so R0 wins first.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= ST_IDLE;
            last_q    <= 1'b1;
            gnt_q     <= 1'b0;
            cnt_q     <= {TO_CNT_W{1'b0}};
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= {ADDR_W{1'b0}};
            pwdata_q  <= {DATA_W{1'b0}};
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            rdata0_q  <= {DATA_W{1'b0}};
            rdata1_q  <= {DATA_W{1'b0}};
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            cnt_q     <= cnt_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
        end
    end

    assign PSEL     = psel_q;
    assign PENABLE  = penable_q;
    assign PWRITE   = pwrite_q;
    assign PADDR    = paddr_q;
    assign PWDATA   = pwdata_q;
    assign R0_DONE  = done0_q;
    assign R0_RDATA = rdata0_q;
    assign R0_ERR   = err0_q;
    assign R1_DONE  = done1_q;
    assign R1_RDATA = rdata1_q;
    assign R1_ERR   = err1_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter: a transfer table plus hand-written
// sequences for arbitration, timeout, reset and disabled-timeout behaviour.
// Instance "a" has an 8-cycle timeout, instance "z" has the timeout disabled;
// both see identical stimulus.

module tb_apb_master_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_req, r0_write, r1_req, r1_write;
    logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
    logic [31:0] prdata;
    logic        pready, pslverr;

    logic        a_r0_done, a_r0_err, a_r1_done, a_r1_err;
    logic [31:0] a_r0_rdata, a_r1_rdata;
    logic        a_psel, a_penable, a_pwrite;
    logic [31:0] a_paddr, a_pwdata;

    logic        z_r0_done, z_r0_err, z_r1_done, z_r1_err;
    logic [31:0] z_r0_rdata, z_r1_rdata;
    logic        z_psel, z_penable, z_pwrite;
    logic [31:0] z_paddr, z_pwdata;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    apb_master_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8), .TO_CNT_W(8)) u_a (
        .PCLK(clk), .PRESET(rst),
        .R0_REQ(r0_req), .R0_WRITE(r0_write), .R0_ADDR(r0_addr), .R0_WDATA(r0_wdata),
        .R0_DONE(a_r0_done), .R0_RDATA(a_r0_rdata), .R0_ERR(a_r0_err),
        .R1_REQ(r1_req), .R1_WRITE(r1_write), .R1_ADDR(r1_addr), .R1_WDATA(r1_wdata),
        .R1_DONE(a_r1_done), .R1_RDATA(a_r1_rdata), .R1_ERR(a_r1_err),
        .PSEL(a_psel), .PENABLE(a_penable), .PWRITE(a_pwrite), .PADDR(a_paddr),
        .PWDATA(a_pwdata), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
    );

    apb_master_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(0), .TO_CNT_W(8)) u_z (
        .PCLK(clk), .PRESET(rst),
        .R0_REQ(r0_req), .R0_WRITE(r0_write), .R0_ADDR(r0_addr), .R0_WDATA(r0_wdata),
        .R0_DONE(z_r0_done), .R0_RDATA(z_r0_rdata), .R0_ERR(z_r0_err),
        .R1_REQ(r1_req), .R1_WRITE(r1_write), .R1_ADDR(r1_addr), .R1_WDATA(r1_wdata),
        .R1_DONE(z_r1_done), .R1_RDATA(z_r1_rdata), .R1_ERR(z_r1_err),
        .PSEL(z_psel), .PENABLE(z_penable), .PWRITE(z_pwrite), .PADDR(z_paddr),
        .PWDATA(z_pwdata), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
    );

    typedef struct {
        logic        who;       // 0 = R0, 1 = R1
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;     // PREADY=0 cycles before PREADY=1
        logic [31:0] prdata;
        logic        slverr;
        logic        hold;      // keep REQ high until the DONE cycle
        logic [31:0] exp_rdata;
        logic        exp_err;
    } xfer_t;

    xfer_t       tbl [5];
    logic [31:0] held_rdata [2];
    logic        held_err   [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        r0_req = 1'b0; r1_req = 1'b0;
        pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        held_rdata[0] = 32'h0; held_rdata[1] = 32'h0;
        held_err[0]   = 1'b0;  held_err[1]   = 1'b0;
    endtask

    task automatic drive_req(input logic who, input logic on);
        if (who) r1_req = on;
        else     r0_req = on;
    endtask

    // One complete transfer on instance "a" with cycle-by-cycle checks.
    task automatic do_xfer(input xfer_t v);
        logic        d_own, d_oth, e_own, e_oth;
        logic [31:0] rd_own, rd_oth;
        @(posedge clk); #1;
        if (v.who) begin
            r1_write = v.write; r1_addr = v.addr; r1_wdata = v.wdata;
        end else begin
            r0_write = v.write; r0_addr = v.addr; r0_wdata = v.wdata;
        end
        drive_req(v.who, 1'b1);
        pready = 1'b0;
        @(negedge clk);
        chk("idle_psel", {31'h0, a_psel}, 32'h0);
        @(posedge clk); #1;
        if (!v.hold) drive_req(v.who, 1'b0);
        @(negedge clk);
        chk("setup_psel", {31'h0, a_psel}, 32'h1);
        chk("setup_penable", {31'h0, a_penable}, 32'h0);
        chk("setup_paddr", a_paddr, v.addr);
        chk("setup_pwrite", {31'h0, a_pwrite}, {31'h0, v.write});
        if (v.write) chk("setup_pwdata", a_pwdata, v.wdata);
        for (int i = 0; i <= v.waits; i++) begin
            @(posedge clk); #1;
            pready  = (i == v.waits);
            prdata  = v.prdata;
            pslverr = v.slverr;
            @(negedge clk);
            chk("access_en", {30'h0, a_psel, a_penable}, 32'h3);
            chk("access_paddr", a_paddr, v.addr);
            chk("access_pwrite", {31'h0, a_pwrite}, {31'h0, v.write});
            if (v.write) chk("access_pwdata", a_pwdata, v.wdata);
        end
        @(posedge clk); #1;
        pready = 1'b0; pslverr = 1'b0;
        drive_req(v.who, 1'b0);
        @(negedge clk);
        d_own  = v.who ? a_r1_done  : a_r0_done;
        d_oth  = v.who ? a_r0_done  : a_r1_done;
        rd_own = v.who ? a_r1_rdata : a_r0_rdata;
        rd_oth = v.who ? a_r0_rdata : a_r1_rdata;
        e_own  = v.who ? a_r1_err   : a_r0_err;
        e_oth  = v.who ? a_r0_err   : a_r1_err;
        chk("done_own", {31'h0, d_own}, 32'h1);
        chk("done_other", {31'h0, d_oth}, 32'h0);
        chk("done_bus_idle", {30'h0, a_psel, a_penable}, 32'h0);
        chk("rdata", rd_own, v.exp_rdata);
        chk("err", {31'h0, e_own}, {31'h0, v.exp_err});
        chk("other_rdata_held", rd_oth, held_rdata[~v.who]);
        chk("other_err_held", {31'h0, e_oth}, {31'h0, held_err[~v.who]});
        held_rdata[v.who] = v.exp_rdata;
        held_err[v.who]   = v.exp_err;
        @(posedge clk); #1;
        @(negedge clk);
        d_own  = v.who ? a_r1_done  : a_r0_done;
        rd_own = v.who ? a_r1_rdata : a_r0_rdata;
        chk("done_pulse_once", {31'h0, d_own}, 32'h0);
        chk("rdata_hold", rd_own, v.exp_rdata);
    endtask

    initial begin
        int          pen_cnt, grants, overlap, ok_cnt;
        logic        seen;
        logic [31:0] rr_exp [4];
        xfer_t       t;

        r0_write = 1'b0; r0_addr = 32'h0; r0_wdata = 32'h0;
        r1_write = 1'b0; r1_addr = 32'h0; r1_wdata = 32'h0;

        //          who   wr    addr          wdata         wt prdata        serr  hold  exp_rdata     exp_err
        tbl[0] = '{1'b0, 1'b0, 32'h0000_1004, 32'h0000_0000, 0, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 32'h0000_0010, 32'hA5A5_0001, 3, 32'h1234_5678, 1'b1, 1'b0, 32'h0000_0000, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 1, 32'hCAFE_F00D, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 32'h0000_0044, 32'h0F0F_0F0F, 2, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 32'h0000_0008, 32'h0000_0000, 0, 32'h1111_2222, 1'b1, 1'b1, 32'h1111_2222, 1'b1};

        // Reset state.
        do_reset();
        @(negedge clk);
        chk("rst_apb", {27'h0, a_psel, a_penable, a_pwrite, a_r0_done, a_r1_done}, 32'h0);
        chk("rst_paddr", a_paddr, 32'h0);
        chk("rst_rdata0", a_r0_rdata, 32'h0);
        chk("rst_err", {30'h0, a_r0_err, a_r1_err}, 32'h0);

        // Transfer table.
        for (int k = 0; k < 5; k++) do_xfer(tbl[k]);

        // Timeout abort after 8 ACCESS cycles, then a normal transfer.
        do_reset();
        t = '{1'b1, 1'b0, 32'h0000_0030, 32'h0, 0, 32'h7777_8888, 1'b0, 1'b1, 32'h7777_8888, 1'b0};
        do_xfer(t);
        @(posedge clk); #1;
        r1_write = 1'b0; r1_addr = 32'h0000_0034; r1_req = 1'b1; pready = 1'b0;
        pen_cnt = 0; seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (a_penable) pen_cnt++;
            if (a_r1_done) seen = 1'b1;
        end
        r1_req = 1'b0;
        chk("to_done_seen", {31'h0, seen}, 32'h1);
        chk("to_penable_cycles", pen_cnt, 32'd8);
        chk("to_psel_dropped", {31'h0, a_psel}, 32'h0);
        chk("to_err", {31'h0, a_r1_err}, 32'h1);
        chk("to_rdata_zero", a_r1_rdata, 32'h0);
        held_rdata[1] = 32'h0; held_err[1] = 1'b1;
        do_xfer(tbl[0]);

        // Round robin with both requesting continuously from reset.
        do_reset();
        r0_addr = 32'h0000_0100; r0_write = 1'b0;
        r1_addr = 32'h0000_0200; r1_write = 1'b0;
        rr_exp[0] = 32'h100; rr_exp[1] = 32'h200; rr_exp[2] = 32'h100; rr_exp[3] = 32'h200;
        grants = 0; overlap = 0;
        @(posedge clk); #1;
        r0_req = 1'b1; r1_req = 1'b1; pready = 1'b1; prdata = 32'h0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (a_r0_done && a_r1_done) overlap++;
            if (a_psel && !a_penable && grants < 4) begin
                chk("rr_grant", a_paddr, rr_exp[grants]);
                grants++;
            end
        end
        chk("rr_grant_count", grants, 32'd4);
        chk("rr_done_overlap", overlap, 32'd0);
        r0_req = 1'b0; r1_req = 1'b0; pready = 1'b0;

        // Reset in the middle of ACCESS.
        do_reset();
        @(posedge clk); #1;
        r0_addr = 32'h0000_0050; r0_write = 1'b0; r0_req = 1'b1; pready = 1'b0;
        @(posedge clk); #1;
        r0_req = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_access_penable", {31'h0, a_penable}, 32'h1);
        #2 rst = 1'b1;
        #1 chk("rst_async_bus", {30'h0, a_psel, a_penable}, 32'h0);
        @(posedge clk); #1;
        chk("rst_no_done", {30'h0, a_r0_done, a_r1_done}, 32'h0);
        r0_addr = 32'h0000_0060; r1_addr = 32'h0000_0070;
        r0_req = 1'b1; r1_req = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_first_psel", {31'h0, a_psel}, 32'h1);
        chk("rst_first_grant_r0", a_paddr, 32'h0000_0060);
        r0_req = 1'b0; r1_req = 1'b0;

        // Timeout disabled: 300 wait cycles, then normal completion.
        do_reset();
        @(posedge clk); #1;
        r0_addr = 32'h0000_0040; r0_write = 1'b0; r0_req = 1'b1; pready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        ok_cnt = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (z_psel && z_penable && !z_r0_done) ok_cnt++;
            @(posedge clk); #1;
        end
        chk("nto_wait_cycles", ok_cnt, 32'd300);
        pready = 1'b1; prdata = 32'h600D_F00D;
        @(posedge clk); #1;
        pready = 1'b0; r0_req = 1'b0;
        @(negedge clk);
        chk("nto_done", {31'h0, z_r0_done}, 32'h1);
        chk("nto_rdata", z_r0_rdata, 32'h600D_F00D);
        chk("nto_err", {31'h0, z_r0_err}, 32'h0);
        chk("nto_bus_idle", {30'h0, z_psel, z_penable}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
